// File: rtl/axi_slave_mem_responder_if.sv
// AXI4 bus bundle between a host-memory master and axi_slave_mem_responder.
// The slave modport is the responder's view; the master modport drives requests.
interface axi_slave_mem_responder_if #(
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 1024
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid, awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast, wvalid, wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid, bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid, arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast, rvalid, rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );
endinterface

// File: rtl/axi_slave_mem_responder.sv
// AXI4 slave memory responder: one write and one read burst in flight, independent channels.
// Optional AXI_SLV_MEM_RANGE_CHECK_EN: out-of-range bursts get DECERR instead of wrapping.
module axi_slave_mem_responder #(
  parameter int ID_WIDTH       = 2,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 1024,
  parameter int MEM_DEPTH_LOG2 = 8
) (
  input  logic clk,
  input  logic rst_n,
  axi_slave_mem_responder_if.slave s_axi
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(NBYTES);
  localparam int DEPTH  = 1 << MEM_DEPTH_LOG2;
  localparam int SW     = ((MEM_DEPTH_LOG2 > 8) ? MEM_DEPTH_LOG2 : 8) + 1;
  localparam logic [2:0] SIZE_FULL = 3'(OFF);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_e;
  typedef enum logic       {R_IDLE, R_DATA}         rst_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Both address channels stay closed until the first edge after reset release.
  logic rdy_q;

  idx_t       aw_idx, ar_idx;
  logic       aw_rng_err, ar_rng_err;
  logic [1:0] aw_resp, ar_resp;

  assign aw_idx = s_axi.awaddr[OFF +: MEM_DEPTH_LOG2];
  assign ar_idx = s_axi.araddr[OFF +: MEM_DEPTH_LOG2];

`ifdef AXI_SLV_MEM_RANGE_CHECK_EN
  assign aw_rng_err = ((s_axi.awaddr >> (OFF + MEM_DEPTH_LOG2)) != '0) ||
                      ((SW'(aw_idx) + SW'(s_axi.awlen)) > SW'(DEPTH - 1));
  assign ar_rng_err = ((s_axi.araddr >> (OFF + MEM_DEPTH_LOG2)) != '0) ||
                      ((SW'(ar_idx) + SW'(s_axi.arlen)) > SW'(DEPTH - 1));
`else
  assign aw_rng_err = 1'b0;
  assign ar_rng_err = 1'b0;
`endif

  assign aw_resp = aw_rng_err ? DECERR :
                   (s_axi.awburst == 2'b01 && s_axi.awsize == SIZE_FULL) ? OKAY : SLVERR;
  assign ar_resp = ar_rng_err ? DECERR :
                   (s_axi.arburst == 2'b01 && s_axi.arsize == SIZE_FULL) ? OKAY : SLVERR;

  // ---------------- write channel ----------------
  wst_e                wst_q, wst_d;
  logic [ID_WIDTH-1:0] wid_q, wid_d;
  idx_t                widx_q, widx_d;
  logic [7:0]          wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [1:0]          wresp_q, wresp_d;
  logic                wok_q, wok_d;
  logic                mem_we, awready, wready, bvalid;

  always_comb begin
    wst_d   = wst_q;
    wid_d   = wid_q;
    widx_d  = widx_q;
    wlen_d  = wlen_q;
    wcnt_d  = wcnt_q;
    wresp_d = wresp_q;
    wok_d   = wok_q;
    mem_we  = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (wst_q)
      W_IDLE: begin
        awready = rdy_q;
        if (rdy_q && s_axi.awvalid) begin
          wst_d   = W_DATA;
          wid_d   = s_axi.awid;
          widx_d  = aw_idx;
          wlen_d  = s_axi.awlen;
          wcnt_d  = 8'd0;
          wresp_d = aw_resp;
          wok_d   = (aw_resp == OKAY);
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (s_axi.wvalid) begin
          // Storage is decided by the address phase; a wlast mismatch only taints the response.
          mem_we = wok_q;
          widx_d = widx_q + 1'b1;
          wcnt_d = wcnt_q + 8'd1;
          if (s_axi.wlast != (wcnt_q == wlen_q)) wresp_d = SLVERR;
          if (wcnt_q == wlen_q) wst_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (s_axi.bready) wst_d = W_IDLE;
      end
      default: wst_d = W_IDLE;
    endcase
  end

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bid     = wid_q;
  assign s_axi.bresp   = wresp_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++)
        if (s_axi.wstrb[b]) mem[widx_q][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
    end
  end

  // ---------------- read channel ----------------
  rst_e                rdst_q, rdst_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  idx_t                ridx_q, ridx_d, rd_idx;
  logic [7:0]          rlen_q, rlen_d, rcnt_q, rcnt_d, rd_beat;
  logic [1:0]          rresp_q, rresp_d;
  logic                rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                rd_load, rd_ok, arready;

  always_comb begin
    rdst_d   = rdst_q;
    rid_d    = rid_q;
    ridx_d   = ridx_q;
    rlen_d   = rlen_q;
    rcnt_d   = rcnt_q;
    rresp_d  = rresp_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rdata_d  = rdata_q;
    arready  = 1'b0;
    rd_load  = 1'b0;
    rd_idx   = ridx_q;
    rd_ok    = (rresp_q == OKAY);
    rd_beat  = rcnt_q;
    unique case (rdst_q)
      R_IDLE: begin
        arready = rdy_q;
        // First beat is fetched on the AR edge itself so rvalid rises the next cycle.
        if (rdy_q && s_axi.arvalid) begin
          rdst_d  = R_DATA;
          rid_d   = s_axi.arid;
          rlen_d  = s_axi.arlen;
          rresp_d = ar_resp;
          rd_load = 1'b1;
          rd_idx  = ar_idx;
          rd_ok   = (ar_resp == OKAY);
          rd_beat = 8'd0;
        end
      end
      R_DATA: begin
        if (!rvalid_q || s_axi.rready) begin
          if (rvalid_q && rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            rdst_d   = R_IDLE;
          end else begin
            rd_load = 1'b1;
          end
        end
      end
      default: rdst_d = R_IDLE;
    endcase
    if (rd_load) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? mem[rd_idx] : '0;
      rlast_d  = (rd_beat == rlen_d);
      ridx_d   = rd_idx + 1'b1;
      rcnt_d   = rd_beat + 8'd1;
    end
  end

  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rid     = rid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q    <= 1'b0;
      wst_q    <= W_IDLE;
      wid_q    <= '0;
      widx_q   <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      wresp_q  <= OKAY;
      wok_q    <= 1'b0;
      rdst_q   <= R_IDLE;
      rid_q    <= '0;
      ridx_q   <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rresp_q  <= OKAY;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rdy_q    <= 1'b1;
      wst_q    <= wst_d;
      wid_q    <= wid_d;
      widx_q   <= widx_d;
      wlen_q   <= wlen_d;
      wcnt_q   <= wcnt_d;
      wresp_q  <= wresp_d;
      wok_q    <= wok_d;
      rdst_q   <= rdst_d;
      rid_q    <= rid_d;
      ridx_q   <= ridx_d;
      rlen_q   <= rlen_d;
      rcnt_q   <= rcnt_d;
      rresp_q  <= rresp_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule
